// File: rtl/multiplier_iter.sv
// Iterative shift-add signed multiply-accumulate: out_a = b*q + r.
// Rebuilds a dividend from the iterative divider's quotient/remainder, one bit per cycle.
`timescale 1ns / 1ps

module multiplier_iter #(
  parameter int unsigned BIT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [BIT_WIDTH-1:0]   in_b,
  input  logic [BIT_WIDTH:0]     in_q,
  input  logic [BIT_WIDTH-1:0]   in_r,
  output logic                   out_flag,
  output logic                   out_ready,
  output logic [2*BIT_WIDTH+1:0] out_a
);

  localparam int unsigned CW = $clog2(BIT_WIDTH + 3);
  localparam int unsigned AW = 2 * BIT_WIDTH + 1;
  localparam int unsigned OW = 2 * BIT_WIDTH + 2;

  localparam logic [CW-1:0] CntIdle = '0;
  localparam logic [CW-1:0] CntFin  = CW'(BIT_WIDTH + 2);

  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        mb_q, mb_d;
  logic [BIT_WIDTH:0]   mq_q, mq_d;
  logic                 sign_q, sign_d;
  logic [OW-1:0]        r_q, r_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic                 flag_q, flag_d;
  logic                 ready_q, ready_d;
  logic [OW-1:0]        a_q, a_d;

  logic                 is_idle, is_fin, accept;
  logic [BIT_WIDTH-1:0] abs_b;
  logic [BIT_WIDTH:0]   abs_q;
  logic [OW-1:0]        mag;

  assign is_idle = (count_q == CntIdle);
  assign is_fin  = (count_q == CntFin);
  assign accept  = is_idle && in_en;

  // Two's-complement negation of the most negative value wraps to the
  // same bit pattern, which is exactly its magnitude read as unsigned.
  assign abs_b = in_b[BIT_WIDTH-1] ? (~in_b + 1'b1) : in_b;
  assign abs_q = in_q[BIT_WIDTH]   ? (~in_q + 1'b1) : in_q;
  assign mag   = {1'b0, acc_q};

  // State register (count doubles as the FSM state).
  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= CntIdle;
      flag_q  <= 1'b0;
      ready_q <= 1'b0;
      a_q     <= '0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      ready_q <= ready_d;
      a_q     <= a_d;
    end
  end

  // Operand and accumulator registers need no reset: they are reloaded on accept.
  always_ff @(posedge clock) begin
    mb_q   <= mb_d;
    mq_q   <= mq_d;
    sign_q <= sign_d;
    r_q    <= r_d;
    acc_q  <= acc_d;
  end

  // Next-state logic.
  always_comb begin
    count_d = count_q;
    if (is_idle) begin
      if (in_en) begin
        count_d = CW'(1);
      end
    end else if (is_fin) begin
      count_d = CntIdle;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Datapath and registered outputs.
  always_comb begin
    mb_d    = mb_q;
    mq_d    = mq_q;
    sign_d  = sign_q;
    r_d     = r_q;
    acc_d   = acc_q;
    flag_d  = 1'b0;
    ready_d = ready_q;
    a_d     = a_q;

    if (accept) begin
      mb_d    = AW'(abs_b);
      mq_d    = abs_q;
      sign_d  = in_b[BIT_WIDTH-1] ^ in_q[BIT_WIDTH];
      r_d     = {{(OW - BIT_WIDTH){in_r[BIT_WIDTH-1]}}, in_r};
      acc_d   = '0;
      ready_d = 1'b0;
    end else if (is_fin) begin
      a_d     = (sign_q ? (~mag + 1'b1) : mag) + r_q;
      flag_d  = 1'b1;
      ready_d = 1'b1;
    end else if (!is_idle) begin
      // LSB-first: mb is pre-shifted so bit k-1 of mq weights mb << (k-1).
      if (mq_q[0]) begin
        acc_d = acc_q + mb_q;
      end
      mq_d = mq_q >> 1;
      mb_d = mb_q << 1;
    end
  end

  assign out_flag  = flag_q;
  assign out_ready = ready_q;
  assign out_a     = a_q;

endmodule

// File: tb/tb_multiplier_iter.sv
// Directed bench for multiplier_iter at BIT_WIDTH=8: results, latency, busy
// behaviour, back-to-back accepts and mid-operation reset.
`timescale 1ns / 1ps

module tb_multiplier_iter;

  localparam int W  = 8;
  localparam int QW = W + 1;
  localparam int OW = 2 * W + 2;
  // Edges from the accept edge to the edge that raises out_flag (flag cycle is the 11th).
  localparam int LAT = W + 2;

  logic          clock = 1'b0;
  logic          rst;
  logic          in_en;
  logic [W-1:0]  in_b;
  logic [QW-1:0] in_q;
  logic [W-1:0]  in_r;
  logic          out_flag;
  logic          out_ready;
  logic [OW-1:0] out_a;

  int vectors = 0;
  int miscompares = 0;

  multiplier_iter #(.BIT_WIDTH(W)) dut (
    .clock    (clock),
    .rst      (rst),
    .in_en    (in_en),
    .in_b     (in_b),
    .in_q     (in_q),
    .in_r     (in_r),
    .out_flag (out_flag),
    .out_ready(out_ready),
    .out_a    (out_a)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait; an expired bound shows up as a wrong latency.
  task automatic wait_flag(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_flag && lat < 40);
  endtask

  task automatic run(input string tag, input int b, input int q, input int r, input int exp);
    int lat;
    in_b  = W'(b);
    in_q  = QW'(q);
    in_r  = W'(r);
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    check({tag, "/ready_cleared"}, out_ready, 0);
    wait_flag(lat);
    check({tag, "/latency"}, lat, LAT);
    check({tag, "/a"}, $signed(out_a), exp);
    check({tag, "/ready"}, out_ready, 1);
    tick();
    check({tag, "/flag_drop"}, out_flag, 0);
    check({tag, "/a_hold"}, $signed(out_a), exp);
  endtask

  initial begin
    int lat;
    int flags;
    int bl[8] = '{-128, -7, -1, 1, 3, 7, 100, 127};

    rst   = 1'b1;
    in_en = 1'b0;
    in_b  = '0;
    in_q  = '0;
    in_r  = '0;
    tick();
    tick();
    check("reset/flag", out_flag, 0);
    check("reset/ready", out_ready, 0);
    check("reset/a", $signed(out_a), 0);
    rst = 1'b0;
    tick();

    run("basic", 7, -5, 3, -32);
    run("roundtrip_m37", 7, -5, -2, -37);
    run("ext_nn", -128, -256, -128, 32640);
    run("ext_np", -128, 255, -128, -32768);
    run("ext_pp", 127, 255, 127, 32512);
    run("zero_b", 0, -200, 5, 5);
    run("zero_q", -3, 0, -7, -7);

    // Divider round-trip: truncating quotient, remainder takes the dividend's sign.
    for (int a = -128; a <= 127; a += 17) begin
      foreach (bl[i]) begin
        int q;
        q = a / bl[i];
        run($sformatf("rt_a%0d_b%0d", a, bl[i]), bl[i], q, a - bl[i] * q, a);
      end
    end

    // in_en held high: second operands change mid-run and must be ignored.
    in_b  = W'(3);
    in_q  = QW'(4);
    in_r  = W'(1);
    in_en = 1'b1;
    tick();
    in_b = W'(5);
    in_q = QW'(6);
    in_r = W'(0);
    wait_flag(lat);
    check("b2b/first_latency", lat, LAT);
    check("b2b/first_a", $signed(out_a), 13);
    tick();
    check("b2b/reaccept_ready", out_ready, 0);
    check("b2b/reaccept_flag", out_flag, 0);
    in_b = W'(9);
    in_q = QW'(9);
    in_r = W'(9);
    wait_flag(lat);
    in_en = 1'b0;
    check("b2b/second_latency", lat, LAT);
    check("b2b/second_a", $signed(out_a), 30);
    flags = 0;
    repeat (15) begin
      tick();
      if (out_flag) flags++;
    end
    check("b2b/no_third", flags, 0);
    check("b2b/a_hold", $signed(out_a), 30);

    // Reset while count=4.
    in_b  = W'(7);
    in_q  = QW'(-5);
    in_r  = W'(3);
    in_en = 1'b1;
    tick();
    in_en = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst/flag", out_flag, 0);
    check("midrst/ready", out_ready, 0);
    check("midrst/a", $signed(out_a), 0);
    rst = 1'b0;
    flags = 0;
    repeat (15) begin
      tick();
      if (out_flag) flags++;
    end
    check("midrst/no_flag", flags, 0);
    run("post_rst", -128, -256, -128, 32640);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
